// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared defaults and output-mode encodings for the
//                parameterised serial sequence detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  // Default detector geometry
  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_CNT_W   = 8;

  // Output mode selection values for mealy_sel
  localparam logic MODE_MOORE = 1'b0;
  localparam logic MODE_MEALY = 1'b1;

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its all-ones value instead of
//                wrapping; synchronous clear, asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] c_max = '1;

  logic [W-1:0] r_cnt;

  // Count increments, hold at the maximum, clear has priority over inc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Serial pattern detector with selectable overlapping or
//                non-overlapping matching, Mealy/Moore output selection and
//                a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             clr,
  input  logic             mealy_sel,
  output logic             out,
  output logic [PAT_W-1:0] hist,
  output logic [CNT_W-1:0] match_cnt
);

  // fill must be able to represent PAT_W itself
  localparam int               FILL_W     = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] c_fill_arm = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_out_q;

  logic [PAT_W-1:0]  w_window;
  logic              w_armed;
  logic              w_hit;

  // Candidate window: the stored bits plus the bit being offered this cycle.
  // A hit needs PAT_W-1 valid stored bits so the window is fully genuine.
  assign w_window = {r_hist[PAT_W-2:0], in};
  assign w_armed  = (r_fill >= c_fill_arm);
  assign w_hit    = en & ~clr & w_armed & (w_window == PATTERN);

  // History shift register and valid-bit fill tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (en) begin
      r_hist <= w_window;
      // Non-overlapping mode restarts the fill so the matched bits are not reused
      if (w_hit && (OVERLAP == 0)) begin
        r_fill <= '0;
      end else if (r_fill != c_fill_max) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Registered copy of hit, giving a one-cycle-late pulse for Moore mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_q <= 1'b0;
    end else if (clr) begin
      r_out_q <= 1'b0;
    end else begin
      r_out_q <= w_hit;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_hit),
    .cnt (match_cnt)
  );

  // Mode select only steers the output; fill is zero during reset so hit is too
  assign out  = (mealy_sel == MODE_MEALY) ? w_hit : r_out_q;
  assign hist = r_hist;

endmodule : seq_detect_param
`default_nettype wire
